atm_terminal: RTL and testbench

ATM_TERMINAL -- requirements
Module: atm_terminal

---
 rtl/atm_terminal_pkg.sv | 31 +++
 rtl/atm_digit_entry.sv | 46 ++++
 rtl/atm_terminal.sv | 263 ++++++++++++++++++++++++++
 tb/tb_atm_terminal.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_terminal_pkg.sv
// Shared ATM definitions: state/operation codes, key codes, field widths.
package atm_terminal_pkg;

  localparam int unsigned CODE_W     = 3;
  localparam int unsigned KEY_W      = 4;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned ACC_W      = 4;
  localparam int unsigned MAX_DIGITS = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // ATM state codes; operation codes reuse the same encoding so the ATM
  // reports the operation it is serving on atm_state.
  localparam logic [CODE_W-1:0] ATM_WAITING    = 3'd0;
  localparam logic [CODE_W-1:0] ATM_MENU       = 3'd1;
  localparam logic [CODE_W-1:0] ATM_BALANCE    = 3'd2;
  localparam logic [CODE_W-1:0] ATM_WITHDRAW   = 3'd3;
  localparam logic [CODE_W-1:0] ATM_DEPOSIT    = 3'd4;
  localparam logic [CODE_W-1:0] ATM_CHANGE_PIN = 3'd5;
  localparam logic [CODE_W-1:0] ATM_EXIT       = 3'd6;

  localparam logic [KEY_W-1:0] KEY_ENTER  = 4'hA;
  localparam logic [KEY_W-1:0] KEY_CANCEL = 4'hB;

  // True for decimal digit keys 0-9.
  function automatic logic key_is_digit(input logic [KEY_W-1:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/atm_digit_entry.sv
// Shared digit-entry helper: digit counter plus next-value computation for
// BCD shift (PIN) and decimal accumulation (amount). The caller owns the
// value registers; this block only tracks how many digits were taken.
module atm_digit_entry
  import atm_terminal_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              digit_stb,
  input  logic [KEY_W-1:0]  digit,
  input  logic              full_only,
  input  logic [11:0]       cur_bcd_lo,
  input  logic [DATA_W-1:0] cur_bin,
  output logic              accept_c,
  output logic              over_c,
  output logic              enter_ok_c,
  output logic [DATA_W-1:0] nxt_bcd_c,
  output logic [DATA_W-1:0] nxt_bin_c
);

  logic [2:0] cnt_q;
  logic       room_c;

  // Digit acceptance and ENTER qualification from the current count.
  assign room_c     = (cnt_q < 3'(MAX_DIGITS));
  assign accept_c   = digit_stb && room_c;
  assign over_c     = digit_stb && !room_c;
  assign enter_ok_c = full_only ? (cnt_q == 3'(MAX_DIGITS)) : (cnt_q != 3'd0);

  // At most 4 digits are accumulated, so cur_bin <= 999 here and *10+9 fits.
  assign nxt_bcd_c = {cur_bcd_lo, digit};
  assign nxt_bin_c = cur_bin * 16'd10 + DATA_W'(digit);

  // Digit counter; cleared by the owner on every phase change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
    end else if (clr) begin
      cnt_q <= 3'd0;
    end else if (accept_c) begin
      cnt_q <= cnt_q + 3'd1;
    end
  end

endmodule

// File: rtl/atm_terminal.sv
// ATM keypad terminal: collects account, PIN, operation and amount from a
// keypad and runs the request/response handshake with the ATM core.
// Optional idle timeout enabled by defining ATM_TERM_TIMEOUT_EN.
module atm_terminal
  import atm_terminal_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned AUTH_WAIT      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [2:0]  atm_state,
  input  logic [15:0] atm_balance,
  output logic [2:0]  operation,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic [15:0] amount,
  output logic [15:0] disp_balance,
  output logic        disp_valid,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(AUTH_WAIT + 1);

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_ACC    = 4'd1;
  localparam logic [3:0] ST_PIN    = 4'd2;
  localparam logic [3:0] ST_AUTH   = 4'd3;
  localparam logic [3:0] ST_OPSEL  = 4'd4;
  localparam logic [3:0] ST_AMT    = 4'd5;
  localparam logic [3:0] ST_NEWPIN = 4'd6;
  localparam logic [3:0] ST_ISSUE  = 4'd7;
  localparam logic [3:0] ST_RESULT = 4'd8;

  logic [3:0]        state_q, state_d;
  logic [CODE_W-1:0] sel_op_q, sel_op_d;
  logic              issued_q, issued_d;
  logic [AW-1:0]     auth_cnt_q, auth_cnt_d;

  logic [CODE_W-1:0] operation_d;
  logic [ACC_W-1:0]  acc_num_d;
  logic [DATA_W-1:0] pin_d, amount_d, disp_balance_d;
  logic              disp_valid_d, err_d;

  logic              is_digit_c, atm_adv_c, key_c, cancel_c, timeout_c;
  logic              in_entry_c, entry_reset_c, ent_clr_c, ent_digit_c;
  logic              accept_c, over_c, enter_ok_c;
  logic [DATA_W-1:0] nxt_bcd_c, nxt_bin_c;

  // Key qualification; an advancing ATM response swallows a same-cycle key.
  assign is_digit_c = key_is_digit(key_code);
  assign atm_adv_c  = ((state_q == ST_AUTH) && (atm_state == ATM_MENU)) ||
                      ((state_q == ST_ISSUE) && issued_q && (atm_state == sel_op_q));
  assign key_c      = key_valid && !atm_adv_c;
  assign cancel_c   = key_c && (key_code == KEY_CANCEL) && (state_q != ST_IDLE);
  assign in_entry_c = (state_q == ST_PIN) || (state_q == ST_AMT) || (state_q == ST_NEWPIN);
  assign ent_digit_c = key_c && is_digit_c && in_entry_c;
  assign ent_clr_c  = entry_reset_c || (state_d != state_q);

  atm_digit_entry u_digit_entry (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (ent_clr_c),
    .digit_stb  (ent_digit_c),
    .digit      (key_code),
    .full_only  (state_q != ST_AMT),
    .cur_bcd_lo (pin[11:0]),
    .cur_bin    (amount),
    .accept_c   (accept_c),
    .over_c     (over_c),
    .enter_ok_c (enter_ok_c),
    .nxt_bcd_c  (nxt_bcd_c),
    .nxt_bin_c  (nxt_bin_c)
  );

`ifdef ATM_TERM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;

  assign timeout_c = (state_q != ST_IDLE) && !key_valid && !atm_adv_c &&
                     (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Inactivity counter: reloads on any key or state change, parked in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if ((state_d == ST_IDLE) || key_valid || (state_d != state_q)) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TW'(1);
    end
  end
`else
  logic unused_timeout;
  assign timeout_c      = FALSE;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    sel_op_d       = sel_op_q;
    issued_d       = FALSE;
    auth_cnt_d     = '0;
    operation_d    = operation;
    acc_num_d      = acc_num;
    pin_d          = pin;
    amount_d       = amount;
    disp_balance_d = disp_balance;
    disp_valid_d   = FALSE;
    err_d          = FALSE;
    entry_reset_c  = FALSE;

    if (cancel_c || timeout_c) begin
      state_d     = ST_IDLE;
      operation_d = ATM_EXIT;
      acc_num_d   = '0;
      pin_d       = '0;
      amount_d    = '0;
      err_d       = timeout_c;
    end else begin
      case (state_q)
        ST_IDLE: begin
          operation_d = ATM_EXIT;
          if (key_c && is_digit_c) begin
            acc_num_d = key_code;
            state_d   = ST_ACC;
          end
        end
        ST_ACC: begin
          state_d = ST_PIN;
        end
        ST_PIN, ST_NEWPIN: begin
          if (accept_c) begin
            pin_d = nxt_bcd_c;
          end else if (over_c) begin
            err_d = TRUE;
          end else if (key_c && (key_code == KEY_ENTER)) begin
            if (enter_ok_c) begin
              state_d = (state_q == ST_PIN) ? ST_AUTH : ST_ISSUE;
            end else begin
              err_d         = TRUE;
              pin_d         = '0;
              entry_reset_c = TRUE;
            end
          end
        end
        ST_AUTH: begin
          if (atm_state == ATM_MENU) begin
            state_d     = ST_OPSEL;
            operation_d = ATM_MENU;
          end else if (auth_cnt_q == AW'(AUTH_WAIT - 1)) begin
            state_d     = ST_IDLE;
            operation_d = ATM_EXIT;
            pin_d       = '0;
            err_d       = TRUE;
          end else begin
            auth_cnt_d = auth_cnt_q + AW'(1);
          end
        end
        ST_OPSEL: begin
          if (key_c && is_digit_c) begin
            case (key_code)
              4'd1: begin
                sel_op_d = ATM_BALANCE;
                state_d  = ST_ISSUE;
              end
              4'd2: begin
                sel_op_d = ATM_WITHDRAW;
                amount_d = '0;
                state_d  = ST_AMT;
              end
              4'd3: begin
                sel_op_d = ATM_DEPOSIT;
                amount_d = '0;
                state_d  = ST_AMT;
              end
              4'd4: begin
                sel_op_d = ATM_CHANGE_PIN;
                pin_d    = '0;
                state_d  = ST_NEWPIN;
              end
              4'd5: begin
                operation_d = ATM_EXIT;
                pin_d       = '0;
                state_d     = ST_IDLE;
              end
              default: err_d = TRUE;
            endcase
          end
        end
        ST_AMT: begin
          if (accept_c) begin
            amount_d = nxt_bin_c;
          end else if (over_c) begin
            err_d = TRUE;
          end else if (key_c && (key_code == KEY_ENTER)) begin
            if (enter_ok_c) begin
              state_d = ST_ISSUE;
            end else begin
              err_d = TRUE;
            end
          end
        end
        ST_ISSUE: begin
          issued_d = TRUE;
          if (!issued_q) begin
            operation_d = sel_op_q;
          end else if (atm_state == sel_op_q) begin
            issued_d = FALSE;
            state_d  = ST_RESULT;
          end
        end
        ST_RESULT: begin
          disp_balance_d = atm_balance;
          disp_valid_d   = TRUE;
          amount_d       = '0;
          operation_d    = ATM_MENU;
          state_d        = ST_OPSEL;
        end
        default: begin
          state_d     = ST_IDLE;
          operation_d = ATM_EXIT;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_op_q     <= ATM_MENU;
      issued_q     <= FALSE;
      auth_cnt_q   <= '0;
      operation    <= ATM_EXIT;
      acc_num      <= '0;
      pin          <= '0;
      amount       <= '0;
      disp_balance <= '0;
      disp_valid   <= FALSE;
      err          <= FALSE;
      busy         <= FALSE;
    end else begin
      state_q      <= state_d;
      sel_op_q     <= sel_op_d;
      issued_q     <= issued_d;
      auth_cnt_q   <= auth_cnt_d;
      operation    <= operation_d;
      acc_num      <= acc_num_d;
      pin          <= pin_d;
      amount       <= amount_d;
      disp_balance <= disp_balance_d;
      disp_valid   <= disp_valid_d;
      err          <= err_d;
      busy         <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_atm_terminal.sv
// Directed self-checking bench for atm_terminal (TIMEOUT_CYCLES=16).
module tb_atm_terminal;

  localparam logic [2:0] WAITING = 3'd0;
  localparam logic [2:0] MENU    = 3'd1;
  localparam logic [2:0] BAL     = 3'd2;
  localparam logic [2:0] WDR     = 3'd3;
  localparam logic [2:0] CHPIN   = 3'd5;
  localparam logic [2:0] EXITC   = 3'd6;
  localparam logic [3:0] ENTER   = 4'hA;
  localparam logic [3:0] CANCEL  = 4'hB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [2:0]  atm_state;
  logic [15:0] atm_balance;
  logic [2:0]  operation;
  logic [3:0]  acc_num;
  logic [15:0] pin, amount, disp_balance;
  logic        disp_valid, err, busy;

  int   errors = 0;
  int   checks = 0;
  int   err_cnt = 0;
  int   e0;
  int   n;
  logic seen, done;

  always #5 clk = ~clk;

  atm_terminal #(.TIMEOUT_CYCLES(16), .AUTH_WAIT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .atm_state    (atm_state),
    .atm_balance  (atm_balance),
    .operation    (operation),
    .acc_num      (acc_num),
    .pin          (pin),
    .amount       (amount),
    .disp_balance (disp_balance),
    .disp_valid   (disp_valid),
    .err          (err),
    .busy         (busy)
  );

  // Running count of err pulses.
  always @(posedge clk) if (err === 1'b1) err_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_code  = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic wait_dv(output logic hit);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (disp_valid) hit = 1'b1;
    end
  endtask

  // Wait for busy to drop; reports cycles taken and whether err pulsed.
  task automatic wait_idle(input int limit, output logic fin, output logic err_hit, output int cyc);
    fin = 1'b0; err_hit = 1'b0; cyc = 0;
    for (int i = 0; i < limit && !fin; i++) begin
      @(negedge clk);
      cyc++;
      if (err) err_hit = 1'b1;
      if (!busy) fin = 1'b1;
    end
  endtask

  task automatic login(input logic [3:0] acc);
    press(acc);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    press(ENTER);
  endtask

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    atm_state = WAITING; atm_balance = 16'd0;
    #12;
    check("rst_op", operation, EXITC);
    check("rst_acc", acc_num, 0);
    check("rst_pin", pin, 0);
    check("rst_amt", amount, 0);
    check("rst_disp", disp_balance, 0);
    check("rst_dv", disp_valid, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    e0 = err_cnt;

    // Login: account 3, PIN 1234, MENU two cycles after ENTER.
    press(4'd3);
    check("acc_load", acc_num, 3);
    check("acc_busy", busy, 1);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    check("pin_shift", pin, 16'h1234);
    press(ENTER);
    check("auth_op", operation, EXITC);
    idle(2);
    atm_state = MENU;
    idle(1);
    check("opsel_op", operation, MENU);
    check("opsel_acc", acc_num, 3);
    check("opsel_pin", pin, 16'h1234);
    check("login_no_err", err_cnt - e0, 0);

    // Withdraw 150, balance 350.
    press(4'd2);
    check("amt_clear", amount, 0);
    press(ENTER);
    check("amt_empty_enter_err", err, 1);
    press(4'd1); check("amt_1", amount, 1);
    press(4'd5); check("amt_15", amount, 15);
    press(4'd0); check("amt_150", amount, 150);
    press(ENTER);
    idle(1);
    check("issue_op", operation, WDR);
    check("issue_amt", amount, 150);
    atm_balance = 16'd350;
    atm_state   = WDR;
    wait_dv(seen);
    check("wdr_dv", seen, 1);
    check("wdr_disp", disp_balance, 350);
    check("wdr_amt_clr", amount, 0);
    check("wdr_op_menu", operation, MENU);
    atm_state = MENU;

    // Deposit: 4 nines accepted, fifth rejected.
    press(4'd3);
    repeat (4) press(4'd9);
    check("amt_9999", amount, 9999);
    check("amt_4th_no_err", err, 0);
    press(4'd9);
    check("amt_5th_err", err, 1);
    check("amt_hold", amount, 9999);

    // Cancel during amount entry.
    press(CANCEL);
    check("cxl_busy", busy, 0);
    check("cxl_err", err, 0);
    check("cxl_amt", amount, 0);
    check("cxl_acc", acc_num, 0);
    check("cxl_pin", pin, 0);
    check("cxl_op", operation, EXITC);

    // Authentication timeout after AUTH_WAIT cycles.
    atm_state = WAITING;
    login(4'd3);
    wait_idle(20, done, seen, n);
    check("authfail_done", done, 1);
    check("authfail_err", seen, 1);
    check("authfail_cycles", n, 8);
    check("authfail_pin", pin, 0);

    // Short PIN rejected, then valid PIN.
    press(4'd5);
    check("acc5", acc_num, 5);
    press(4'd1); press(4'd2);
    press(ENTER);
    check("shortpin_err", err, 1);
    check("shortpin_pin", pin, 0);
    check("shortpin_busy", busy, 1);
    press(4'd9); press(4'd8); press(4'd7); press(4'd6);
    check("pin_9876", pin, 16'h9876);
    press(ENTER);
    atm_state = MENU;
    idle(1);
    check("login2_op", operation, MENU);

    // Invalid operation key.
    press(4'd7);
    check("badop_err", err, 1);
    check("badop_busy", busy, 1);

    // Change PIN to 4321.
    press(4'd4);
    check("newpin_clr", pin, 0);
    press(4'd4); press(4'd3); press(4'd2); press(4'd1);
    check("newpin_val", pin, 16'h4321);
    press(ENTER);
    idle(1);
    check("chpin_op", operation, CHPIN);
    atm_balance = 16'd1000;
    atm_state   = CHPIN;
    wait_dv(seen);
    check("chpin_dv", seen, 1);
    check("chpin_disp", disp_balance, 1000);
    check("chpin_pin", pin, 16'h4321);
    atm_state = MENU;

    // Reset while a balance request is outstanding.
    press(4'd1);
    idle(1);
    check("bal_op", operation, BAL);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_op", operation, EXITC);
    check("midrst_pin", pin, 0);
    check("midrst_acc", acc_num, 0);
    check("midrst_disp", disp_balance, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;

    // ATM MENU response and CANCEL on the same cycle: response wins.
    atm_state = WAITING;
    login(4'd3);
    atm_state = MENU;
    key_code  = CANCEL;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("prio_busy", busy, 1);
    check("prio_op", operation, MENU);
    check("prio_pin", pin, 16'h1234);

    // Inactivity in OPSEL.
    wait_idle(40, done, seen, n);
`ifdef ATM_TERM_TIMEOUT_EN
    check("tmo_done", done, 1);
    check("tmo_err", seen, 1);
    check("tmo_cycles", n, 16);
    check("tmo_op", operation, EXITC);
`else
    check("notmo_done", done, 0);
    check("notmo_err", seen, 0);
    check("notmo_busy", busy, 1);
    press(4'd5);
    check("exit_busy", busy, 0);
    check("exit_op", operation, EXITC);
    check("exit_pin", pin, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
